prio_cond_reg_bank: RTL and testbench

- Parametrised bank of NCH independent W-bit conditional-update registers.
- Each channel has a priority-resolved update path: async reset, then sync clear, then enable gated by a 2-bit mode.
- Adds per-channel change-detect pulse, saturating change counter and a registered readback port.
- Sits beside control-path logic as the standard enable/mode-selected state holder with built-in activity metrics.

---
 rtl/prio_cond_reg_bank_pkg.sv | 17 +
 rtl/prio_cond_reg_bank_if.sv | 36 +++
 rtl/prio_cond_reg_bank_chan.sv | 65 ++++++
 rtl/prio_cond_reg_bank.sv | 91 +++++++++
 tb/tb_prio_cond_reg_bank.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/prio_cond_reg_bank_pkg.sv
// Shared definitions for the conditional-update register bank.
//   mode_e    : per-channel update mode (hold / load / increment / clear)
//   chan_lsb  : bit offset of channel idx inside a packed per-channel bus
package prio_cond_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_INC  = 2'b10,
    MODE_CLR  = 2'b11
  } mode_e;

  function automatic int unsigned chan_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/prio_cond_reg_bank_if.sv
// Bus bundle for prio_cond_reg_bank.
//   master : drives CLR/EN/MODE/DIN and the readback request, observes results
//   slave  : the register bank side
// Packing: channel i uses MODE[2i+1:2i], DIN/Q[W*i+W-1:W*i],
// UPD_CNT[CNT_W*i+CNT_W-1:CNT_W*i].
interface prio_cond_reg_bank_if #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4,
  parameter int AW    = 2
) ();

  logic                 CLR;
  logic [NCH-1:0]       EN;
  logic [2*NCH-1:0]     MODE;
  logic [NCH*W-1:0]     DIN;
  logic [NCH*W-1:0]     Q;
  logic [NCH-1:0]       CHG;
  logic [NCH*CNT_W-1:0] UPD_CNT;
  logic                 RD_EN;
  logic [AW-1:0]        RD_ADDR;
  logic [W-1:0]         RD_DATA;
  logic                 RD_VLD;
  logic                 RD_ERR;

  modport master (
    output CLR, EN, MODE, DIN, RD_EN, RD_ADDR,
    input  Q, CHG, UPD_CNT, RD_DATA, RD_VLD, RD_ERR
  );

  modport slave (
    input  CLR, EN, MODE, DIN, RD_EN, RD_ADDR,
    output Q, CHG, UPD_CNT, RD_DATA, RD_VLD, RD_ERR
  );

endinterface

// File: rtl/prio_cond_reg_bank_chan.sv
// One channel of the bank: W-bit conditional register, change pulse and
// saturating change counter.
//   CLK, RST : clock, async active-low reset
//   clr      : synchronous clear of q/chg/cnt (overrides en/mode)
//   en, mode : update enable and mode (hold/load/inc/clear)
//   din      : load data
//   q        : register value
//   chg      : 1 for one cycle after an edge where q changed
//   cnt      : saturating count of value changes
module cond_reg_chan
  import prio_cond_reg_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     q,
  output logic             chg,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0] q_nxt;
  logic         changed;

  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: q_nxt = q;
        MODE_LOAD: q_nxt = din;
        MODE_INC:  q_nxt = q + W'(1);
        MODE_CLR:  q_nxt = '0;
        default:   q_nxt = q;
      endcase
    end
  end

  // Activity is defined by the value actually moving, so an equal load or
  // a per-channel clear of an already-zero register is not a change.
  assign changed = (q_nxt != q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q   <= '0;
      chg <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      chg <= 1'b0;
      cnt <= '0;
    end else begin
      q   <= q_nxt;
      chg <= changed;
      if (changed && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prio_cond_reg_bank.sv
// Bank of NCH independent conditional-update registers with change metrics
// and a registered readback port.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active-low
//   bus : slave side of prio_cond_reg_bank_if (CLR, EN, MODE, DIN, Q, CHG,
//         UPD_CNT, RD_EN, RD_ADDR, RD_DATA, RD_VLD, RD_ERR)
// Requires 2**AW >= NCH.
module prio_cond_reg_bank
  import prio_cond_reg_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4,
  parameter int AW    = 2
) (
  input logic                  CLK,
  input logic                  RST,
  prio_cond_reg_bank_if.slave  bus
);

  logic [W-1:0]     q_arr [NCH];
  logic [NCH-1:0]   chg_vec;
  logic [CNT_W-1:0] cnt_arr [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cond_reg_chan #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_chan (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (bus.CLR),
      .en   (bus.EN[g]),
      .mode (bus.MODE[chan_lsb(g, 2) +: 2]),
      .din  (bus.DIN[chan_lsb(g, W) +: W]),
      .q    (q_arr[g]),
      .chg  (chg_vec[g]),
      .cnt  (cnt_arr[g])
    );

    assign bus.Q[chan_lsb(g, W) +: W]               = q_arr[g];
    assign bus.UPD_CNT[chan_lsb(g, CNT_W) +: CNT_W] = cnt_arr[g];
  end

  assign bus.CHG = chg_vec;

  // Readback sees the register outputs before this edge's update, so a
  // read and write of the same channel in one cycle returns the old value.
  logic [W-1:0] rd_mux;
  logic         rd_hit;

  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.RD_ADDR == AW'(i)) begin
        rd_mux = q_arr[i];
        rd_hit = 1'b1;
      end
    end
  end

  logic [W-1:0] rd_data;
  logic         rd_vld;
  logic         rd_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      rd_err  <= 1'b0;
    end else if (bus.RD_EN) begin
      rd_vld <= 1'b1;
      if (rd_hit) begin
        rd_data <= rd_mux;
        rd_err  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_vld <= 1'b0;
      rd_err <= 1'b0;
    end
  end

  assign bus.RD_DATA = rd_data;
  assign bus.RD_VLD  = rd_vld;
  assign bus.RD_ERR  = rd_err;

endmodule

// File: tb/tb_prio_cond_reg_bank.sv
// Self-checking bench for prio_cond_reg_bank (NCH=4, W=8, CNT_W=4, AW=2),
// plus a second NCH=3 instance for out-of-range readback.
module tb_prio_cond_reg_bank;
  import prio_cond_reg_pkg::*;

  logic CLK;
  logic RST;

  prio_cond_reg_bank_if #(.NCH(4), .W(8), .CNT_W(4), .AW(2)) u_if ();
  prio_cond_reg_bank_if #(.NCH(3), .W(8), .CNT_W(4), .AW(2)) u_if3 ();

  prio_cond_reg_bank #(.NCH(4), .W(8), .CNT_W(4), .AW(2)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if.slave)
  );

  prio_cond_reg_bank #(.NCH(3), .W(8), .CNT_W(4), .AW(2)) u_dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if3.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what each channel should hold, by the update rules.
  int unsigned mq   [4];
  int unsigned mcnt [4];
  bit          mchg [4];
  int unsigned mrd;
  bit          mvld;
  bit          merr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mcnt[i] = 0; mchg[i] = 0;
    end
    mrd = 0; mvld = 0; merr = 0;
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q%0d", i),   64'(u_if.Q[i*8 +: 8]),       64'(mq[i]));
      chk($sformatf("chg%0d", i), 64'(u_if.CHG[i]),            64'(mchg[i]));
      chk($sformatf("cnt%0d", i), 64'(u_if.UPD_CNT[i*4 +: 4]), 64'(mcnt[i]));
    end
    chk("rd_vld",  64'(u_if.RD_VLD),  64'(mvld));
    chk("rd_err",  64'(u_if.RD_ERR),  64'(merr));
    chk("rd_data", 64'(u_if.RD_DATA), 64'(mrd));
  endtask

  // Predict from the inputs present before the edge, then compare after it.
  task automatic tick();
    int unsigned nq [4];
    int unsigned nrd;
    bit nvld, nerr;
    for (int i = 0; i < 4; i++) begin
      int unsigned md;
      md = u_if.MODE[2*i +: 2];
      nq[i] = mq[i];
      if (u_if.EN[i]) begin
        if (md == 1)      nq[i] = u_if.DIN[8*i +: 8];
        else if (md == 2) nq[i] = (mq[i] + 1) % 256;
        else if (md == 3) nq[i] = 0;
      end
    end
    nrd = mrd; nvld = 0; nerr = 0;
    if (u_if.RD_EN) begin
      nvld = 1;
      if (u_if.RD_ADDR < 4) nrd = mq[u_if.RD_ADDR];
      else begin nrd = 0; nerr = 1; end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (u_if.CLR) begin
        mchg[i] = 0; mcnt[i] = 0; mq[i] = 0;
      end else begin
        mchg[i] = (nq[i] != mq[i]);
        if (mchg[i] && mcnt[i] < 15) mcnt[i]++;
        mq[i] = nq[i];
      end
    end
    mrd = nrd; mvld = nvld; merr = nerr;
    check_model();
  endtask

  task automatic idle_inputs();
    u_if.CLR = 0; u_if.EN = '0; u_if.MODE = '0; u_if.DIN = '0;
    u_if.RD_EN = 0; u_if.RD_ADDR = '0;
  endtask

  typedef struct {
    logic        clr;
    logic [3:0]  en;
    logic [7:0]  mode;
    logic [31:0] din;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] exp_q;
    logic [3:0]  exp_chg;
    logic [7:0]  exp_rd;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // clr, en, mode, din, rd_en, rd_addr | q, chg, rd_data, vld, err
    tbl[0]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_005A, 1'b0, 2'd0, 32'h0000_005A, 4'b0001, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_005A, 1'b0, 2'd0, 32'h0000_005A, 4'b0000, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 8'h10, 32'h00FE_0000, 1'b0, 2'd0, 32'h00FE_005A, 4'b0100, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 8'h20, 32'h0000_0000, 1'b0, 2'd0, 32'h00FF_005A, 4'b0100, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0100, 8'h20, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_005A, 4'b0100, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0100, 8'h20, 32'h0000_0000, 1'b1, 2'd0, 32'h0001_005A, 4'b0100, 8'h5A, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 8'h00, 32'hAAAA_AAAA, 1'b1, 2'd2, 32'h0001_005A, 4'b0000, 8'h01, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'b1111, 8'h55, 32'hAAAA_AAAA, 1'b0, 2'd0, 32'h0000_0000, 4'b0000, 8'h01, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1000, 8'h40, 32'h3300_0000, 1'b0, 2'd0, 32'h3300_0000, 4'b1000, 8'h01, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b1000, 8'h40, 32'h4400_0000, 1'b1, 2'd3, 32'h4400_0000, 4'b1000, 8'h33, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b1000, 8'hC0, 32'h0000_0000, 1'b1, 2'd1, 32'h0000_0000, 4'b1000, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 8'h00, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 4'b0000, 8'h00, 1'b0, 1'b0};

    RST = 0;
    idle_inputs();
    u_if3.CLR = 0; u_if3.EN = '0; u_if3.MODE = '0; u_if3.DIN = '0;
    u_if3.RD_EN = 0; u_if3.RD_ADDR = '0;
    model_reset();
    #12;
    check_model();
    @(negedge CLK);
    RST = 1;

    // Directed table from power-up state.
    for (int r = 0; r < 12; r++) begin
      u_if.CLR = tbl[r].clr; u_if.EN = tbl[r].en; u_if.MODE = tbl[r].mode;
      u_if.DIN = tbl[r].din; u_if.RD_EN = tbl[r].rd_en; u_if.RD_ADDR = tbl[r].rd_addr;
      tick();
      chk($sformatf("tbl%0d_q", r),   64'(u_if.Q),       64'(tbl[r].exp_q));
      chk($sformatf("tbl%0d_chg", r), 64'(u_if.CHG),     64'(tbl[r].exp_chg));
      chk($sformatf("tbl%0d_rd", r),  64'(u_if.RD_DATA), 64'(tbl[r].exp_rd));
      chk($sformatf("tbl%0d_vld", r), 64'(u_if.RD_VLD),  64'(tbl[r].exp_vld));
      chk($sformatf("tbl%0d_err", r), 64'(u_if.RD_ERR),  64'(tbl[r].exp_err));
    end

    // Saturation: ch1 toggles 01/02 for 20 changes after a clear.
    idle_inputs();
    u_if.CLR = 1;
    tick();
    u_if.CLR = 0;
    u_if.EN = 4'b0010; u_if.MODE = 8'h04;
    for (int k = 0; k < 20; k++) begin
      u_if.DIN = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      tick();
      chk("sat_cnt1", 64'(u_if.UPD_CNT[7:4]), 64'((k + 1 > 15) ? 15 : k + 1));
    end

    // Out-of-range readback on the three-channel instance.
    u_if3.RD_EN = 1; u_if3.RD_ADDR = 2'd3;
    @(posedge CLK); #1;
    chk("n3_err",  64'(u_if3.RD_ERR),  64'(1));
    chk("n3_vld",  64'(u_if3.RD_VLD),  64'(1));
    chk("n3_data", 64'(u_if3.RD_DATA), 64'(0));
    u_if3.RD_ADDR = 2'd2;
    @(posedge CLK); #1;
    chk("n3_in_err", 64'(u_if3.RD_ERR), 64'(0));
    u_if3.RD_EN = 0;
    @(posedge CLK); #1;
    chk("n3_idle_vld", 64'(u_if3.RD_VLD), 64'(0));

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      u_if.CLR = ($urandom_range(19) == 0);
      u_if.EN = 4'($urandom);
      u_if.MODE = 8'($urandom);
      for (int i = 0; i < 4; i++)
        u_if.DIN[8*i +: 8] = ($urandom_range(2) == 0) ? 8'(mq[i]) : 8'($urandom);
      u_if.RD_EN = 1'($urandom);
      u_if.RD_ADDR = 2'($urandom);
      tick();
    end

    // Reset mid-stream: outputs clear at once, before any edge.
    u_if.EN = 4'hF; u_if.MODE = 8'h55; u_if.DIN = 32'h1234_5678; u_if.RD_EN = 1;
    tick();
    tick();
    #3;
    RST = 0;
    #1;
    model_reset();
    check_model();
    chk("rst_q_all", 64'(u_if.Q), 64'(0));
    @(posedge CLK); #1;
    check_model();
    RST = 1;
    idle_inputs();
    u_if.EN = 4'b0001; u_if.MODE = 8'h01; u_if.DIN = 32'h0000_00C3;
    tick();
    chk("post_rst_cnt0", 64'(u_if.UPD_CNT[3:0]), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
